// File: rtl/lpc_host.sv
// LPC bus initiator: issues single-byte I/O read/write cycles from a valid/ready
// request port and returns a one-cycle response pulse. Split AD in/out/oe pads.
module lpc_host #(
  parameter int unsigned SYNC_TIMEOUT = 8,
  parameter int unsigned ABORT_LEN    = 4
) (
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_error,
  output logic        lpc_frame,
  output logic [3:0]  lpc_ad_out,
  output logic        lpc_ad_oe,
  input  logic [3:0]  lpc_ad_in
);

  localparam int unsigned CNT_MAX = (ABORT_LEN > SYNC_TIMEOUT) ? ABORT_LEN : SYNC_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [3:0] SYNC_READY = 4'h0;
  localparam logic [3:0] SYNC_ERROR = 4'hA;
  localparam logic [3:0] AD_IDLE    = 4'hF;

  typedef enum logic [3:0] {
    IDLE, START, CYCT, ADDR, WDATA, HTAR, SYNC, RDATA, PTAR, ABORT
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             write_q;
  logic [15:0]      addr_q;
  logic [7:0]       wdata_q;
  logic [7:0]       rdata_q;
  logic             err_q;
  logic             accept;
  logic             sync_hit;
  logic             frame_d;
  logic             oe_d;
  logic [3:0]       ad_d;

  assign accept   = req_valid && req_ready && (state == IDLE);
  assign sync_hit = (lpc_ad_in == SYNC_READY) || (lpc_ad_in == SYNC_ERROR);

  // Next state and per-state cycle counter
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (accept) state_d = START;
      START: state_d = CYCT;
      CYCT:  state_d = ADDR;
      ADDR:  if (cnt == CNT_W'(3)) state_d = write_q ? WDATA : HTAR;
      WDATA: if (cnt == CNT_W'(1)) state_d = HTAR;
      HTAR:  if (cnt == CNT_W'(1)) state_d = SYNC;
      SYNC: begin
        if (sync_hit)                                state_d = write_q ? PTAR : RDATA;
        else if (cnt == CNT_W'(SYNC_TIMEOUT - 1))    state_d = ABORT;
      end
      RDATA: if (cnt == CNT_W'(1)) state_d = PTAR;
      PTAR:  if (cnt == CNT_W'(1)) state_d = IDLE;
      ABORT: if (cnt == CNT_W'(ABORT_LEN - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = ((state_d != state) || (state == IDLE)) ? '0 : cnt + CNT_W'(1);
  end

  // Pad values for the state being entered, so the pads come straight from flops
  always_comb begin
    frame_d = 1'b1;
    oe_d    = 1'b0;
    ad_d    = AD_IDLE;
    case (state_d)
      START: begin
        frame_d = 1'b0;
        oe_d    = 1'b1;
        ad_d    = 4'h0;
      end
      CYCT: begin
        oe_d = 1'b1;
        ad_d = {2'b00, write_q, 1'b0};
      end
      ADDR: begin
        oe_d = 1'b1;
        case (cnt_d[1:0])
          2'd0:    ad_d = addr_q[15:12];
          2'd1:    ad_d = addr_q[11:8];
          2'd2:    ad_d = addr_q[7:4];
          default: ad_d = addr_q[3:0];
        endcase
      end
      WDATA: begin
        oe_d = 1'b1;
        ad_d = cnt_d[0] ? wdata_q[7:4] : wdata_q[3:0];
      end
      HTAR:  oe_d = ~cnt_d[0];
      ABORT: begin
        frame_d = 1'b0;
        oe_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge lpc_clock) begin
    if (lpc_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b0;
      lpc_frame  <= 1'b1;
      lpc_ad_oe  <= 1'b0;
      lpc_ad_out <= AD_IDLE;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 8'h00;
      rsp_error  <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 8'h00;
      rdata_q    <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      req_ready  <= (state_d == IDLE);
      lpc_frame  <= frame_d;
      lpc_ad_oe  <= oe_d;
      lpc_ad_out <= ad_d;
      rsp_valid  <= 1'b0;
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= 1'b0;
      end
      // An error SYNC completes like ready but flags the response
      if ((state == SYNC) && (lpc_ad_in == SYNC_ERROR)) err_q <= 1'b1;
      if (state == RDATA) begin
        if (cnt[0]) rdata_q[7:4] <= lpc_ad_in;
        else        rdata_q[3:0] <= lpc_ad_in;
      end
      if ((state == PTAR) && (state_d == IDLE)) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= write_q ? 8'h00 : rdata_q;
        rsp_error <= err_q;
      end
      if ((state == ABORT) && (state_d == IDLE)) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= 8'h00;
        rsp_error <= 1'b1;
      end
    end
  end

endmodule
